// File: rtl/ahb_slave_mem_ws.sv
// AHB-Lite slave memory: configurable width, wait states, byte lanes.
// Ports: HCLK/HRESETN (sync active-low), AHB-Lite slave inputs,
// HRDATA/HREADYOUT/HRESP outputs. HBURST/HPROT/HMASTLOCK ignored.
// Optional error window compiled in with AHBSLV_ERRWIN_EN.
module ahb_slave_mem_ws #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32,
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 0,
  parameter logic [AWIDTH-1:0] ERR_BASE = '0,
  parameter logic [AWIDTH-1:0] ERR_MASK = '0,
  parameter INITFILE = " "
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              HSEL,
  input  logic              HREADYIN,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [AWIDTH-1:0] HADDR,
  input  logic [DWIDTH-1:0] HWDATA,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic              HMASTLOCK,
  output logic [DWIDTH-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int BYTES = DWIDTH / 8;
  localparam int LSB = $clog2(BYTES);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
`ifdef AHBSLV_ERRWIN_EN
    , S_ERR1
    , S_ERR2
`endif
  } state_t;

  logic [DWIDTH-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic              hready_q, hready_d;
  logic              accept;
  logic              mem_we;
  logic [IW-1:0]     word_idx;
  logic [BYTES-1:0]  lane_en;
  int                lo;

  // hready_q is high only in IDLE/DATA/ERR2, the states that may
  // take a new address phase.
  assign accept = HSEL & HREADYIN & HTRANS[1] & hready_q;

`ifdef AHBSLV_ERRWIN_EN
  logic hresp_q, hresp_d;
  logic err_hit;
  assign err_hit = ((HADDR & ERR_MASK) == (ERR_BASE & ERR_MASK))
                   && (ERR_MASK != '0);
  assign HRESP = hresp_q;
`else
  assign HRESP = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    if (accept) begin
      addr_d  = HADDR;
      write_d = HWRITE;
      size_d  = HSIZE;
    end
    unique case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
`ifdef AHBSLV_ERRWIN_EN
      S_ERR1: state_d = S_ERR2;
`endif
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          if (WS != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end else begin
            state_d = S_DATA;
          end
`ifdef AHBSLV_ERRWIN_EN
          // error transfers skip wait states
          if (err_hit) begin
            state_d = S_ERR1;
            cnt_d   = '0;
          end
`endif
        end
      end
    endcase
    hready_d = (state_d != S_WAIT);
`ifdef AHBSLV_ERRWIN_EN
    hready_d = hready_d && (state_d != S_ERR1);
    hresp_d  = (state_d == S_ERR1) || (state_d == S_ERR2);
`endif
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      hready_q <= 1'b1;
`ifdef AHBSLV_ERRWIN_EN
      hresp_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      hready_q <= hready_d;
`ifdef AHBSLV_ERRWIN_EN
      hresp_q  <= hresp_d;
`endif
    end
  end

  assign HREADYOUT = hready_q;

  // A byte lane is enabled when it sits in the same size-aligned
  // block as the address; this also truncates misaligned addresses.
  always_comb begin
    lo = int'(addr_q[LSB-1:0]);
    for (int b = 0; b < BYTES; b++) begin
      lane_en[b] = ((b >> size_q) == (lo >> size_q));
    end
    word_idx = IW'(32'(addr_q[AWIDTH-1:LSB]) % 32'(DEPTH));
    mem_we   = (state_q == S_DATA) && write_q;
  end

  always_ff @(posedge HCLK) begin
    if (HRESETN && mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (lane_en[b]) begin
          mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HRDATA = (state_q == S_DATA && !write_q) ? mem[word_idx] : '0;

  logic unused;
  assign unused = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK
`ifndef AHBSLV_ERRWIN_EN
                    , ERR_BASE, ERR_MASK
`endif
                   };

endmodule

// File: tb/tb_ahb_slave_mem_ws.sv
// Bench for ahb_slave_mem_ws: three slaves (32b/0ws, 32b/3ws, 64b)
// on one shared bus, directed transfers with hand-computed results.
module tb_ahb_slave_mem_ws;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [11:0] haddr;
  logic [63:0] hwdata;
  logic [2:0]  rdy;
  logic [2:0]  rsp;
  logic [31:0] rdata0, rdata1;
  logic [63:0] rdata2;
  logic        hready_bus;
  logic [63:0] rd_cur;
  int          cur = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign hready_bus = rdy[cur];
  assign rd_cur = (cur == 2) ? rdata2 :
                  (cur == 1) ? {32'h0, rdata1} : {32'h0, rdata0};

  ahb_slave_mem_ws #(
    .AWIDTH(12), .DWIDTH(32), .DEPTH(256), .WAIT_STATES(0),
    .ERR_BASE(12'h300), .ERR_MASK(12'h300)
  ) u0 (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel[0]),
    .HREADYIN(hready_bus), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata[31:0]),
    .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HRDATA(rdata0), .HREADYOUT(rdy[0]), .HRESP(rsp[0])
  );

  ahb_slave_mem_ws #(
    .AWIDTH(10), .DWIDTH(32), .DEPTH(256), .WAIT_STATES(3)
  ) u1 (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel[1]),
    .HREADYIN(hready_bus), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HADDR(haddr[9:0]), .HWDATA(hwdata[31:0]),
    .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HRDATA(rdata1), .HREADYOUT(rdy[1]), .HRESP(rsp[1])
  );

  ahb_slave_mem_ws #(
    .AWIDTH(10), .DWIDTH(64), .DEPTH(256), .WAIT_STATES(0)
  ) u2 (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel[2]),
    .HREADYIN(hready_bus), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HADDR(haddr[9:0]), .HWDATA(hwdata),
    .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HRDATA(rdata2), .HREADYOUT(rdy[2]), .HRESP(rsp[2])
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One non-pipelined transfer; returns in its final data cycle.
  task automatic xfer(input int s, input logic wr,
                      input logic [11:0] a, input logic [2:0] sz,
                      input logic [63:0] wd, output logic [63:0] rd,
                      output int nw, output logic wresp,
                      output logic dresp);
    cur = s;
    @(posedge clk); #1;
    hsel = '0;
    hsel[s] = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    haddr = a;
    hsize = sz;
    @(posedge clk); #1;
    hsel = '0;
    htrans = 2'b00;
    hwdata = wd;
    nw = 0;
    wresp = 1'b0;
    while (!hready_bus && nw < 20) begin
      if (rsp[s]) wresp = 1'b1;
      nw++;
      @(posedge clk); #1;
    end
    if (!hready_bus) chk("timeout", 64'd1, 64'd0);
    rd = rd_cur;
    dresp = rsp[s];
  endtask

  logic [63:0] rd;
  int          nw;
  logic        wr_, dr_;

  initial begin
    rst_n = 1'b0;
    hsel = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize = 3'd2;
    haddr = '0;
    hwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", {61'h0, rdy}, 64'h7);
    chk("rst_resp", {61'h0, rsp}, 64'h0);
    chk("rst_rd0", {32'h0, rdata0}, 64'h0);
    chk("rst_rd2", rdata2, 64'h0);
    rst_n = 1'b1;

    // idle transfer with select: zero-wait, no access
    @(posedge clk); #1;
    hsel = 3'b001;
    htrans = 2'b00;
    @(posedge clk); #1;
    chk("idle_rdy", {63'h0, rdy[0]}, 64'h1);
    chk("idle_rd", {32'h0, rdata0}, 64'h0);
    hsel = '0;

    // back-to-back write then read, zero wait
    cur = 0;
    @(posedge clk); #1;
    hsel = 3'b001;
    htrans = 2'b10;
    hwrite = 1'b1;
    haddr = 12'h010;
    hsize = 3'd2;
    chk("b2b_rdy_a", {63'h0, rdy[0]}, 64'h1);
    @(posedge clk); #1;
    hwdata = 64'hA5A5_1234;
    hwrite = 1'b0;
    chk("b2b_rdy_w", {63'h0, rdy[0]}, 64'h1);
    @(posedge clk); #1;
    hsel = '0;
    htrans = 2'b00;
    chk("b2b_rdy_r", {63'h0, rdy[0]}, 64'h1);
    chk("b2b_data", {32'h0, rdata0}, 64'hA5A5_1234);
    @(posedge clk); #1;
    chk("b2b_after", {32'h0, rdata0}, 64'h0);

    // wrap: 0x400 aliases word 0 at depth 256
    xfer(0, 1'b1, 12'h400, 3'd2, 64'hCAFE, rd, nw, wr_, dr_);
    xfer(0, 1'b0, 12'h000, 3'd2, 64'h0, rd, nw, wr_, dr_);
    chk("wrap_data", rd, 64'hCAFE);

`ifdef AHBSLV_ERRWIN_EN
    xfer(0, 1'b1, 12'h304, 3'd2, 64'h1, rd, nw, wr_, dr_);
    chk("err_w_waits", 64'(nw), 64'd1);
    chk("err_w_resp1", {63'h0, wr_}, 64'h1);
    chk("err_w_resp2", {63'h0, dr_}, 64'h1);
    xfer(0, 1'b0, 12'h304, 3'd2, 64'h0, rd, nw, wr_, dr_);
    chk("err_r_waits", 64'(nw), 64'd1);
    chk("err_r_resp2", {63'h0, dr_}, 64'h1);
    chk("err_r_data", rd, 64'h0);
`else
    xfer(0, 1'b1, 12'h304, 3'd2, 64'h1357, rd, nw, wr_, dr_);
    chk("noerr_waits", 64'(nw), 64'd0);
    chk("noerr_resp", {63'h0, dr_}, 64'h0);
    xfer(0, 1'b0, 12'h304, 3'd2, 64'h0, rd, nw, wr_, dr_);
    chk("noerr_data", rd, 64'h1357);
`endif

    // wait states
    xfer(1, 1'b1, 12'h000, 3'd2, 64'h1111_2222, rd, nw, wr_, dr_);
    chk("ws_w_waits", 64'(nw), 64'd3);
    xfer(1, 1'b0, 12'h000, 3'd2, 64'h0, rd, nw, wr_, dr_);
    chk("ws_r_waits", 64'(nw), 64'd3);
    chk("ws_r_resp", {62'h0, wr_, dr_}, 64'h0);
    chk("ws_r_data", rd, 64'h1111_2222);

    // byte lanes on 64-bit slave
    xfer(2, 1'b1, 12'h008, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF,
         rd, nw, wr_, dr_);
    xfer(2, 1'b1, 12'h00B, 3'd0, 64'h0000_0000_5A00_0000,
         rd, nw, wr_, dr_);
    xfer(2, 1'b0, 12'h008, 3'd3, 64'h0, rd, nw, wr_, dr_);
    chk("lane_byte", rd, 64'hFFFF_FFFF_5AFF_FFFF);
    xfer(2, 1'b1, 12'h00E, 3'd1, 64'hBEEF_0000_0000_0000,
         rd, nw, wr_, dr_);
    xfer(2, 1'b0, 12'h008, 3'd3, 64'h0, rd, nw, wr_, dr_);
    chk("lane_half", rd, 64'hBEEF_FFFF_5AFF_FFFF);
    xfer(2, 1'b1, 12'h00D, 3'd2, 64'h1234_5678_0000_0000,
         rd, nw, wr_, dr_);
    xfer(2, 1'b0, 12'h00C, 3'd3, 64'h0, rd, nw, wr_, dr_);
    chk("lane_misal", rd, 64'h1234_5678_5AFF_FFFF);

    // reset during a wait cycle abandons the write
    cur = 1;
    @(posedge clk); #1;
    hsel = 3'b010;
    htrans = 2'b10;
    hwrite = 1'b1;
    haddr = 12'h000;
    hsize = 3'd2;
    @(posedge clk); #1;
    hsel = '0;
    htrans = 2'b00;
    hwdata = 64'hDEAD;
    chk("rst_inwait", {63'h0, rdy[1]}, 64'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_rdy", {63'h0, rdy[1]}, 64'h1);
    chk("rst_mid_resp", {63'h0, rsp[1]}, 64'h0);
    chk("rst_mid_rd", {32'h0, rdata1}, 64'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    xfer(1, 1'b0, 12'h000, 3'd2, 64'h0, rd, nw, wr_, dr_);
    chk("rst_nowrite", rd, 64'h1111_2222);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
